clock_divider_multi: RTL
========================

Name: clock_divider_multi

Overview:
- Multi-channel, runtime-programmable clock divider producing divided-clock enables / slow square waves for LED blink, sample strobes and timeouts.
- Each channel has an independent period and high-time, a registered square-wave output, and a one-cycle tick at each period start.
- Period and high-time updates are glitch-free: new values take effect only at a period boundary.
- A global sync input phase-aligns all channels.

Parameters:
- NUM_CH, 4, number of independent divider channels.
- CNT_W, 32, counter, period and high-time width in bits.
- DEFAULT_PERIOD, 20000000, period (clk cycles) loaded into shadow registers at reset.
- DEFAULT_HIGH, DEFAULT_PERIOD/2, high-time (clk cycles) loaded into shadow registers at reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset, synchronously released externally.
- en  in  NUM_CH  per-channel enable.
- period  in  NUM_CH*CNT_W  per-channel period in cycles; channel i at bits [i*CNT_W +: CNT_W].
- high_cnt  in  NUM_CH*CNT_W  per-channel high-time in cycles, same packing as period.
- sync  in  1  one-cycle restart of all enabled channels.
- div_out  out  NUM_CH  divided square wave per channel.
- tick  out  NUM_CH  one-cycle pulse at each period start per channel.

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-period):
  - cnt = 0, en_q = 0, div_out = 0, tick = 0.
  - period_q = DEFAULT_PERIOD, high_q = DEFAULT_HIGH.
- Per-channel registered state: cnt[CNT_W], period_q, high_q, en_q.
- Outputs are registers, computed from next-state values so they never glitch. Invariant in every cycle:
  - div_out = en_q && (cnt < high_q)
  - tick = en_q && (cnt == 0)
- Effective period P = max(period_q, 1); a period input of 0 is treated as 1.
- en low:
  - cnt held at 0, en_q = 0, div_out = 0, tick = 0.
  - period_q and high_q reload from the inputs every cycle.
- en rising edge (en high, en_q low): next cycle en_q = 1, cnt = 0, shadows loaded from the inputs, so tick = 1 and div_out = (high_cnt > 0).
- Running (en_q = 1, en high):
  - If cnt == P-1: cnt becomes 0 and period_q/high_q reload from the inputs (the boundary load).
  - Otherwise cnt increments by 1.
  - Input changes mid-period have no effect until the boundary.
- Result with P >= 2: div_out is high for high_q cycles, then low for P-high_q cycles; tick fires every P cycles.
- Degenerate cases:
  - high_q == 0: div_out constant 0.
  - high_q >= P: div_out constant 1 while enabled.
  - P == 1: cnt stays 0, tick high every cycle, div_out = (high_q >= 1).
- sync (priority over wrap and increment):
  - Every channel with en high: cnt becomes 0 and shadows reload next cycle, giving tick = 1.
  - Channels with en low are unaffected.
  - sync held high keeps cnt at 0, so tick stays high continuously.
- en falling: next cycle cnt = 0 and div_out = tick = 0, regardless of position in the period.
- No arithmetic overflow: cnt never exceeds P-1 <= 2^CNT_W-2; comparisons are unsigned, CNT_W bits.
- Channels are fully independent except for sync.

Decomposition:
- Package clock_divider_pkg holds:
  - the CNT_W default;
  - the DEFAULT_PERIOD and DEFAULT_HIGH defaults;
  - a function that clamps a period of 0 to 1.
- Sub-module clock_divider_ch: one channel (cnt, shadows, en_q, div_out, tick).
  - Instantiated NUM_CH times in a generate loop.
  - sync is fanned out to every instance.

Test Plan:
- Reset: assert rst_n low mid-run with en high -> div_out = 0 and tick = 0 immediately (asynchronous); after release with en low, outputs stay 0.
- Basic: ch0 period = 4, high_cnt = 1, raise en -> over 5 cycles cnt is 0,1,2,3,0; div_out is 1,0,0,0,1; tick is 1,0,0,0,1.
- Glitch-free update: ch1 period = 10, high = 5 running; at cnt = 3 change to period = 6, high = 2 -> the current period completes 10 cycles with 5 high; the next period is 6 cycles with 2 high.
- Degenerate values:
  - period = 0 -> tick every cycle.
  - high = 0 -> div_out stays 0.
  - period = 5, high = 7 -> div_out stays 1; tick every 5 cycles.
- Sync: ch0 period = 4 and ch1 period = 7 free-running at different phases, ch2 disabled; pulse sync -> next cycle tick on ch0 and ch1 simultaneously; ch2 div_out and tick stay 0.
- Enable drop: ch3 period = 8, high = 4, drop en at cnt = 2 -> next cycle div_out = 0 and tick = 0; re-raise en -> tick = 1, div_out = 1 on the first enabled cycle.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
// A period of 0 is clamped to 1 so the wrap compare never underflows.
package clock_divider_pkg;

   localparam int unsigned DEF_CNT_W  = 32;
   localparam int unsigned DEF_PERIOD = 20_000_000;
   localparam int unsigned DEF_HIGH   = DEF_PERIOD / 2;

   function automatic logic [63:0] clamp_period(input logic [63:0] p);
      return (p == 64'd0) ? 64'd1 : p;
   endfunction

endpackage

// File: rtl/clock_divider_ch.sv
// One divider channel: counter, shadowed period/high-time, registered
// square wave and period-start tick.
module clock_divider_ch
   import clock_divider_pkg::*;
#(
   parameter int unsigned CNT_W          = DEF_CNT_W,
   parameter int unsigned DEFAULT_PERIOD = DEF_PERIOD,
   parameter int unsigned DEFAULT_HIGH   = DEF_HIGH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             sync_i,
   input  logic [CNT_W-1:0] period_i,
   input  logic [CNT_W-1:0] high_i,
   output logic             div_o,
   output logic             tick_o
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [CNT_W-1:0] p_eff;
   logic             en_q, div_q, tick_q;
   logic             div_d, tick_d, wrap;

   assign p_eff = CNT_W'(clamp_period(64'(period_q)));
   assign wrap  = (cnt_q == (p_eff - ONE));

   always_comb begin
      cnt_d    = cnt_q;
      period_d = period_q;
      high_d   = high_q;
      // idle, start, sync and wrap all restart and take the new shadows
      if (!en_i || !en_q || sync_i || wrap) begin
         cnt_d    = '0;
         period_d = period_i;
         high_d   = high_i;
      end else begin
         cnt_d = cnt_q + ONE;
      end
      div_d  = en_i && (cnt_d < high_d);
      tick_d = en_i && (cnt_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         period_q <= CNT_W'(DEFAULT_PERIOD);
         high_q   <= CNT_W'(DEFAULT_HIGH);
         en_q     <= 1'b0;
         div_q    <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         period_q <= period_d;
         high_q   <= high_d;
         en_q     <= en_i;
         div_q    <= div_d;
         tick_q   <= tick_d;
      end
   end

   assign div_o  = div_q;
   assign tick_o = tick_q;

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider; channels share only the
// sync restart.
module clock_divider_multi
   import clock_divider_pkg::*;
#(
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned CNT_W          = DEF_CNT_W,
   parameter int unsigned DEFAULT_PERIOD = DEF_PERIOD,
   parameter int unsigned DEFAULT_HIGH   = DEFAULT_PERIOD / 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH*CNT_W-1:0] period,
   input  logic [NUM_CH*CNT_W-1:0] high_cnt,
   input  logic                    sync,
   output logic [NUM_CH-1:0]       div_out,
   output logic [NUM_CH-1:0]       tick
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clock_divider_ch #(
         .CNT_W          (CNT_W),
         .DEFAULT_PERIOD (DEFAULT_PERIOD),
         .DEFAULT_HIGH   (DEFAULT_HIGH)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .en_i     (en[g]),
         .sync_i   (sync),
         .period_i (period[g*CNT_W +: CNT_W]),
         .high_i   (high_cnt[g*CNT_W +: CNT_W]),
         .div_o    (div_out[g]),
         .tick_o   (tick[g])
      );
   end

endmodule
